// File: rtl/sample_addr_gen.sv
// sample_addr_gen: divides clk by a clamped speed divisor to produce sample
// ticks, and on each accepted tick issues a req/ack read for the next audio
// sample address inside a fixed [START_ADDR, END_ADDR] window.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   speed_freq[31:0]  requested divisor (clk cycles per sample)
//   play              1 = divider runs, 0 = paused (counter holds)
//   dir               0 = forward (+1), 1 = reverse (-1), sampled per tick
//   restart           pulse: jump pointer to window start (fwd) / end (rev)
//   rd_ack            flash reader accepted the current request
//   rd_req            read request, held until rd_ack
//   rd_addr           address of the current request
//   sample_tick       1-cycle pulse after each divider terminal count
//   wrap              1-cycle pulse when the pointer wraps on an accepted tick
//   overrun_cnt[7:0]  saturating count of ticks dropped while busy
//   cur_div[31:0]     divisor currently in effect
module sample_addr_gen #(
    parameter int unsigned ADDR_W      = 23,
    parameter int unsigned START_ADDR  = 0,
    parameter int unsigned END_ADDR    = 'h7FFFF,
    parameter int unsigned DEFAULT_DIV = 2273,
    parameter int unsigned MIN_DIV     = 1036,
    parameter int unsigned MAX_DIV     = 12600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       speed_freq,
    input  logic              play,
    input  logic              dir,
    input  logic              restart,
    input  logic              rd_ack,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              sample_tick,
    output logic              wrap,
    output logic [7:0]        overrun_cnt,
    output logic [31:0]       cur_div
);

    localparam int unsigned DIV_W = 32;
    localparam int unsigned OVR_W = 8;

    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);
    localparam logic [DIV_W-1:0]  DEF_D   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0]  MIN_D   = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0]  MAX_D   = DIV_W'(MAX_DIV);
    localparam logic [OVR_W-1:0]  OVR_MAX = '1;

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  cur_div_q, cur_div_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_req_q, rd_req_d;
    logic              sample_tick_q, sample_tick_d;
    logic              wrap_q, wrap_d;
    logic [OVR_W-1:0]  overrun_q, overrun_d;

    logic              term_cnt;
    logic              tick_accept;
    logic [ADDR_W-1:0] ptr_next;
    logic              ptr_wraps;
    logic [DIV_W-1:0]  div_clamped;

    // Terminal count, acceptance, pointer step and divisor clamp
    always_comb begin
        term_cnt    = play && (cnt_q == (cur_div_q - DIV_W'(1)));
        // A request being acked on the terminal-count cycle frees the slot
        tick_accept = !rd_req_q || rd_ack;

        ptr_wraps = 1'b0;
        if (dir) begin
            if (ptr_q == START_A) begin
                ptr_next  = END_A;
                ptr_wraps = 1'b1;
            end else begin
                ptr_next = ptr_q - ADDR_W'(1);
            end
        end else begin
            if (ptr_q == END_A) begin
                ptr_next  = START_A;
                ptr_wraps = 1'b1;
            end else begin
                ptr_next = ptr_q + ADDR_W'(1);
            end
        end

        if (speed_freq < MIN_D) begin
            div_clamped = MIN_D;
        end else if (speed_freq > MAX_D) begin
            div_clamped = MAX_D;
        end else begin
            div_clamped = speed_freq;
        end
    end

    // Next-state: restart > terminal count > idle counting / handshake
    always_comb begin
        cnt_d         = cnt_q;
        cur_div_d     = cur_div_q;
        ptr_d         = ptr_q;
        rd_addr_d     = rd_addr_q;
        rd_req_d      = rd_req_q;
        sample_tick_d = 1'b0;
        wrap_d        = 1'b0;
        overrun_d     = overrun_q;

        if (restart) begin
            cnt_d    = '0;
            ptr_d    = dir ? END_A : START_A;
            rd_req_d = 1'b0;
        end else if (term_cnt) begin
            cnt_d         = '0;
            cur_div_d     = div_clamped;
            sample_tick_d = 1'b1;
            if (tick_accept) begin
                rd_addr_d = ptr_q;
                rd_req_d  = 1'b1;
                ptr_d     = ptr_next;
                wrap_d    = ptr_wraps;
            end else if (overrun_q != OVR_MAX) begin
                overrun_d = overrun_q + OVR_W'(1);
            end
        end else begin
            if (play) begin
                cnt_d = cnt_q + DIV_W'(1);
            end
            if (rd_req_q && rd_ack) begin
                rd_req_d = 1'b0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            cur_div_q     <= DEF_D;
            ptr_q         <= START_A;
            rd_addr_q     <= START_A;
            rd_req_q      <= 1'b0;
            sample_tick_q <= 1'b0;
            wrap_q        <= 1'b0;
            overrun_q     <= '0;
        end else begin
            cnt_q         <= cnt_d;
            cur_div_q     <= cur_div_d;
            ptr_q         <= ptr_d;
            rd_addr_q     <= rd_addr_d;
            rd_req_q      <= rd_req_d;
            sample_tick_q <= sample_tick_d;
            wrap_q        <= wrap_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rd_req      = rd_req_q;
    assign rd_addr     = rd_addr_q;
    assign sample_tick = sample_tick_q;
    assign wrap        = wrap_q;
    assign overrun_cnt = overrun_q;
    assign cur_div     = cur_div_q;

endmodule

// File: tb/tb_sample_addr_gen.sv
// Testbench for sample_addr_gen: randomized play/dir/restart/ack/speed
// traffic against a behavioural model; expected tick results are queued and
// checked by an independent monitor whenever the DUT pulses sample_tick.
module tb_sample_addr_gen;

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned START  = 16;
    localparam int unsigned ENDA   = 31;
    localparam int unsigned NWIN   = ENDA - START + 1;
    localparam int unsigned DEFDIV = 12;
    localparam int unsigned MINDIV = 5;
    localparam int unsigned MAXDIV = 30;

    typedef struct packed {
        logic              wrap;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        ovr;
        logic [31:0]       div;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       speed_freq = 32'd12;
    logic              play = 1'b0;
    logic              dir = 1'b0;
    logic              restart = 1'b0;
    logic              rd_ack = 1'b0;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              sample_tick;
    logic              wrap;
    logic [7:0]        overrun_cnt;
    logic [31:0]       cur_div;

    sample_addr_gen #(
        .ADDR_W(ADDR_W), .START_ADDR(START), .END_ADDR(ENDA),
        .DEFAULT_DIV(DEFDIV), .MIN_DIV(MINDIV), .MAX_DIV(MAXDIV)
    ) dut (
        .clk(clk), .rst(rst), .speed_freq(speed_freq), .play(play),
        .dir(dir), .restart(restart), .rd_ack(rd_ack), .rd_req(rd_req),
        .rd_addr(rd_addr), .sample_tick(sample_tick), .wrap(wrap),
        .overrun_cnt(overrun_cnt), .cur_div(cur_div)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model: time position inside the sample period, pointer as an
    // offset into the window, and the externally visible request state.
    int          m_ph;
    int          m_div;
    int          m_off;
    bit          m_req;
    logic [ADDR_W-1:0] m_addr;
    int          m_ovr;
    int          m_ticks;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int clamp_div(input logic [31:0] s);
        if (s < 32'(MINDIV)) return int'(MINDIV);
        if (s > 32'(MAXDIV)) return int'(MAXDIV);
        return int'(s);
    endfunction

    task automatic model_reset();
        m_ph   = 0;
        m_div  = int'(DEFDIV);
        m_off  = 0;
        m_req  = 1'b0;
        m_addr = ADDR_W'(START);
        m_ovr  = 0;
        sb.delete();
    endtask

    // Advance the model by one clock edge using the inputs present at it
    task automatic model_edge();
        exp_t e;
        if (restart) begin
            m_ph  = 0;
            m_off = dir ? int'(NWIN) - 1 : 0;
            m_req = 1'b0;
        end else if (play && m_ph == m_div - 1) begin
            m_ph = 0;
            m_ticks++;
            m_div = clamp_div(speed_freq);
            e.wrap = 1'b0;
            if (!m_req || rd_ack) begin
                m_addr = ADDR_W'(int'(START) + m_off);
                e.wrap = dir ? (m_off == 0) : (m_off == int'(NWIN) - 1);
                m_off  = dir ? (m_off + int'(NWIN) - 1) % int'(NWIN) : (m_off + 1) % int'(NWIN);
                m_req  = 1'b1;
            end else if (m_ovr < 255) begin
                m_ovr++;
            end
            e.addr = m_addr;
            e.ovr  = 8'(m_ovr);
            e.div  = 32'(m_div);
            sb.push_back(e);
        end else begin
            if (play) m_ph++;
            if (m_req && rd_ack) m_req = 1'b0;
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    // Monitor: compare queued tick results and per-cycle request state
    always @(negedge clk) begin
        if (!rst) begin
            if (sample_tick) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_tick: got tick=1 expected tick=0 at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("tick_rd_addr", 64'(rd_addr), 64'(mon_e.addr));
                    chk("tick_rd_req", 64'(rd_req), 64'd1);
                    chk("tick_wrap", 64'(wrap), 64'(mon_e.wrap));
                    chk("tick_overrun", 64'(overrun_cnt), 64'(mon_e.ovr));
                    chk("tick_cur_div", 64'(cur_div), 64'(mon_e.div));
                end
            end else begin
                if (sb.size() != 0) begin
                    n_chk++;
                    $display("FAIL missed_tick: got tick=0 expected tick=1 at %0t", $time);
                    void'(sb.pop_front());
                end
                chk("idle_wrap", 64'(wrap), 64'd0);
            end
            chk("cyc_rd_req", 64'(rd_req), 64'(m_req));
            chk("cyc_rd_addr", 64'(rd_addr), 64'(m_addr));
            chk("cyc_overrun", 64'(overrun_cnt), 64'(m_ovr));
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_req"}, 64'(rd_req), 64'd0);
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'(START));
        chk({tag, "_tick"}, 64'(sample_tick), 64'd0);
        chk({tag, "_wrap"}, 64'(wrap), 64'd0);
        chk({tag, "_overrun"}, 64'(overrun_cnt), 64'd0);
        chk({tag, "_cur_div"}, 64'(cur_div), 64'(DEFDIV));
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            play    = ($urandom_range(0, 19) != 0);
            restart = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 299) == 0) dir = ~dir;
            if ($urandom_range(0, 39) == 0)
                speed_freq = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
            if (m_req && m_ph == m_div - 1) rd_ack = 1'($urandom_range(0, 1));
            else if (m_req)                 rd_ack = ($urandom_range(0, 3) == 0);
            else                            rd_ack = ($urandom_range(0, 9) == 0);
            tick_clk();
        end
        restart = 1'b0;
        rd_ack  = 1'b0;
    endtask

    // Run until the model has seen `target` ticks; an expired budget is a failure
    task automatic run_until_ticks(input int target, input int budget, input string tag);
        int k = 0;
        while (m_ticks < target && k < budget) begin
            tick_clk();
            k++;
        end
        if (m_ticks < target) begin
            n_chk++;
            $display("FAIL %s_timeout: got %0d ticks expected %0d", tag, m_ticks, target);
        end
    endtask

    initial begin
        int k;
        int t0;
        m_ticks = 0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        rand_cycles(6000);

        // Restart in reverse while a request is outstanding
        play = 1'b1; rd_ack = 1'b0; restart = 1'b0;
        k = 0;
        while (!m_req && k < 200) begin tick_clk(); k++; end
        chk("pre_restart_req", 64'(rd_req), 64'd1);
        dir = 1'b1; restart = 1'b1;
        tick_clk();
        restart = 1'b0;
        chk("restart_rd_req", 64'(rd_req), 64'd0);
        run_until_ticks(m_ticks + 1, 200, "restart_tick");
        chk("restart_first_addr", 64'(rd_addr), 64'(ENDA));

        // Asynchronous reset in the middle of a period
        rand_cycles(7);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Withheld acks: addresses freeze and overruns saturate
        play = 1'b1; dir = 1'b0; rd_ack = 1'b0; restart = 1'b0; speed_freq = 32'd0;
        t0 = m_ticks;
        run_until_ticks(t0 + 4, 500, "ovr3");
        chk("ovr3_count", 64'(overrun_cnt), 64'd3);
        chk("ovr3_frozen_addr", 64'(rd_addr), 64'(START));
        run_until_ticks(t0 + 301, 5000, "ovr_sat");
        chk("ovr_saturated", 64'(overrun_cnt), 64'd255);

        // Ack landing on the terminal-count cycle keeps the request and advances
        k = 0;
        while (m_ph != m_div - 1 && k < 100) begin tick_clk(); k++; end
        rd_ack = 1'b1;
        tick_clk();
        rd_ack = 1'b0;
        chk("tcack_rd_req", 64'(rd_req), 64'd1);
        chk("tcack_rd_addr", 64'(rd_addr), 64'(START + 1));
        chk("tcack_overrun", 64'(overrun_cnt), 64'd255);

        rand_cycles(3000);
        repeat (2) tick_clk();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
